// File: rtl/wb_led_matrix_master.sv
// wb_led_matrix_master
//   Wishbone master that drives a MAX7219-style 8x8 LED matrix through an SPI Wishbone
//   slave. Keeps a local 8x8 framebuffer and turns init/refresh requests into 16-bit
//   register writes (sel = 4'b0011) on one chip-select.
//
//   Optional feature: define LED_MATRIX_AUTO_REFRESH_EN to add a free-running counter
//   that forces a rows pass every REFRESH_CYCLES clocks once init has completed.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   fb_we/addr/data   framebuffer row write (bit7 of fb_data = column 0)
//   intensity         brightness, sampled when the intensity command is issued
//   start             one-cycle request: run init + full refresh
//   busy              high while a sequence is in progress
//   init_done         high once an init sequence has completed after reset
//   adr_o..cyc_o      Wishbone master request signals
//   ack_i             Wishbone acknowledge from the SPI slave
module wb_led_matrix_master #(
    parameter logic [31:0] SPI_BASE = 32'h0000_0000,
    parameter int unsigned CS_IDX   = 0
`ifdef LED_MATRIX_AUTO_REFRESH_EN
    ,
    parameter int unsigned REFRESH_CYCLES = 1_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fb_we,
    input  logic [2:0]  fb_addr,
    input  logic [7:0]  fb_data,
    input  logic [3:0]  intensity,
    input  logic        start,
    output logic        busy,
    output logic        init_done,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StGap} state_e;

    localparam logic [3:0]  FirstRowIdx = 4'd5;
    localparam logic [3:0]  LastIdx     = 4'd12;
    // Chip-selects are active low: all ones except the selected line.
    localparam logic [2:0]  CsSel       = ~(3'b001 << CS_IDX);
    localparam logic [31:0] AdrWord     = {SPI_BASE[31:7], CsSel, 4'b0000};

    state_e      state_q;
    logic [3:0]  idx_q;
    logic        full_run_q;
    logic        start_pend_q;
    logic        dirty_q;
    logic        init_done_q;
    logic [7:0]  fb_q [8];

    logic        launch;
    logic [3:0]  load_idx;
    logic [15:0] load_word;
    logic [2:0]  fb_row;
    logic [3:0]  row_reg;
    logic        dirty_set;
    logic        dirty_clr;
    logic        refresh_wrap;

    assign busy      = (state_q != StIdle);
    assign init_done = init_done_q;

    // Decide whether a new request is launched this cycle and which command it is.
    always_comb begin
        launch   = 1'b0;
        load_idx = idx_q + 4'd1;
        case (state_q)
            StIdle: begin
                // start has priority over a pending rows refresh
                load_idx = start_pend_q ? 4'd0 : FirstRowIdx;
                launch   = start_pend_q | (dirty_q & init_done_q);
            end
            StGap:   launch = (idx_q != LastIdx);
            default: launch = 1'b0;
        endcase
    end

    // Command table: five init writes, then digit registers 1..8 carrying the rows.
    always_comb begin
        fb_row  = load_idx[2:0] - 3'd5;
        row_reg = load_idx - 4'd4;
        case (load_idx)
            4'd0:    load_word = 16'h0C01;
            4'd1:    load_word = 16'h0900;
            4'd2:    load_word = 16'h0B07;
            4'd3:    load_word = {12'h0A0, intensity};
            4'd4:    load_word = 16'h0F00;
            default: load_word = {4'h0, row_reg, fb_q[fb_row]};
        endcase
    end

    // A write landing on the same edge as the clear keeps the rows dirty.
    assign dirty_clr = launch && (load_idx == FirstRowIdx);
    assign dirty_set = fb_we | (refresh_wrap & init_done_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            full_run_q   <= 1'b0;
            start_pend_q <= 1'b0;
            dirty_q      <= 1'b0;
            init_done_q  <= 1'b0;
            adr_o        <= '0;
            dat_o        <= '0;
            we_o         <= 1'b0;
            sel_o        <= '0;
            stb_o        <= 1'b0;
            cyc_o        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                fb_q[i] <= '0;
            end
        end else begin
            if (fb_we) begin
                fb_q[fb_addr] <= fb_data;
            end
            if (start) begin
                start_pend_q <= 1'b1;
            end
            if (dirty_set) begin
                dirty_q <= 1'b1;
            end else if (dirty_clr) begin
                dirty_q <= 1'b0;
            end

            // Command data is captured here; later framebuffer writes do not touch it.
            if (launch) begin
                idx_q   <= load_idx;
                adr_o   <= AdrWord;
                dat_o   <= {16'h0000, load_word};
                sel_o   <= 4'b0011;
                we_o    <= 1'b1;
                cyc_o   <= 1'b1;
                stb_o   <= 1'b1;
                state_q <= StIssue;
            end

            case (state_q)
                StIdle: begin
                    if (start_pend_q) begin
                        full_run_q   <= 1'b1;
                        // a start arriving on the launch edge is kept for later
                        start_pend_q <= start;
                    end else if (launch) begin
                        full_run_q <= 1'b0;
                    end
                end
                StIssue: begin
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (ack_i) begin
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        we_o    <= 1'b0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (!launch) begin
                        state_q <= StIdle;
                        if (full_run_q) begin
                            init_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LED_MATRIX_AUTO_REFRESH_EN
    localparam logic [31:0] RefreshLast = 32'(REFRESH_CYCLES - 1);

    logic [31:0] refresh_cnt_q;

    assign refresh_wrap = (refresh_cnt_q == RefreshLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_q <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt_q <= '0;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + 32'd1;
        end
    end
`else
    assign refresh_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_wb_led_matrix_master.sv
// Bench for wb_led_matrix_master: random framebuffer traffic, random slave latency,
// transactions checked against a command-table model of the matrix driver.
`timescale 1ns/1ps
module tb_wb_led_matrix_master;

    localparam logic [31:0] SpiBase = 32'h3000_0000;
    localparam logic [31:0] ExpAdr  = 32'h3000_0050;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fb_we;
    logic [2:0]  fb_addr;
    logic [7:0]  fb_data;
    logic [3:0]  intensity;
    logic        start;
    logic        busy;
    logic        init_done;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    wb_led_matrix_master #(
        .SPI_BASE(SpiBase),
        .CS_IDX(1)
`ifdef LED_MATRIX_AUTO_REFRESH_EN
        ,
        .REFRESH_CYCLES(200)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .intensity(intensity),
        .start(start),
        .busy(busy),
        .init_done(init_done),
        .adr_o(adr_o),
        .dat_o(dat_o),
        .we_o(we_o),
        .sel_o(sel_o),
        .stb_o(stb_o),
        .cyc_o(cyc_o),
        .ack_i(ack_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  model_fb [8];
    logic [15:0] run_words [13];
    bit          pend_we = 1'b0;
    logic [2:0]  pend_addr;
    logic [7:0]  pend_data;
    int pos = 0, low_cnt = 0, txn_count = 0, full_runs = 0, row_runs = 0;
    bit cur_full = 1'b0, prev_stb = 1'b0;
    logic [31:0] cur_dat, cur_adr;
    int cyc_num = 0, row_stamp_prev = 0, row_stamp_last = 0;

    always @(posedge clk) cyc_num++;

    function automatic logic [15:0] ref_cmd(input int p);
        case (p)
            0:       return 16'h0C01;
            1:       return 16'h0900;
            2:       return 16'h0B07;
            3:       return {12'h0A0, intensity};
            4:       return 16'h0F00;
            default: return {8'(p - 4), model_fb[p - 5]};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pos = 0; low_cnt = 0; prev_stb = 1'b0; pend_we = 1'b0;
            for (int i = 0; i < 8; i++) model_fb[i] = 8'h00;
        end else begin
            if (stb_o && !prev_stb) begin
                txn_count++;
                check_eq("adr", adr_o, ExpAdr);
                check_eq("sel", 32'(sel_o), 32'h3);
                check_eq("we", 32'(we_o), 32'h1);
                check_eq("cyc", 32'(cyc_o), 32'h1);
                if (pos == 0) begin
                    cur_full = (dat_o[15:0] == 16'h0C01);
                    pos = cur_full ? 0 : 5;
                    if (!cur_full) begin
                        row_stamp_prev = row_stamp_last;
                        row_stamp_last = cyc_num;
                    end
                end else begin
                    check_eq("gap", 32'(low_cnt), 32'd1);
                end
                check_eq("dat", dat_o, {16'h0000, ref_cmd(pos)});
                run_words[pos] = dat_o[15:0];
                cur_dat = dat_o;
                cur_adr = adr_o;
                low_cnt = 0;
                pos++;
                if (pos == 13) begin
                    pos = 0;
                    if (cur_full) full_runs++; else row_runs++;
                end
            end else if (stb_o) begin
                check_eq("hold_dat", dat_o, cur_dat);
                check_eq("hold_adr", adr_o, cur_adr);
                check_eq("hold_cyc", 32'(cyc_o), 32'h1);
            end else if (pos != 0) begin
                low_cnt++;
            end
            prev_stb = stb_o;
            // writes take effect on the edge after they are seen, so apply one late
            if (pend_we) model_fb[pend_addr] = pend_data;
            pend_we   = fb_we;
            pend_addr = fb_addr;
            pend_data = fb_data;
        end
    end

    // ---------------- slave ----------------
    int lat_lo = 3, lat_hi = 3;
    bit stray_req = 1'b0;

    initial begin
        int cnt, lat;
        ack_i = 1'b0; cnt = 0; lat = 3;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_i = 1'b0; cnt = 0;
            end else if (ack_i) begin
                ack_i = 1'b0; cnt = 0;
            end else if (stb_o) begin
                if (cnt == 0) lat = $urandom_range(lat_hi, lat_lo);
                cnt++;
                if (cnt >= lat) ack_i = 1'b1;
            end else if (stray_req) begin
                ack_i = 1'b1; stray_req = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic write_fb(input logic [2:0] a, input logic [7:0] d);
        fb_we = 1'b1; fb_addr = a; fb_data = d; tick(1); fb_we = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 5; i++) begin
            tick(1);
            if (!busy && !stb_o) quiet++; else quiet = 0;
        end
        check_eq(tag, 32'(quiet >= 5), 32'h1);
    endtask

    task automatic wait_busy(input string tag);
        int i = 0;
        while (!busy && i < 100) begin tick(1); i++; end
        check_eq(tag, 32'(busy), 32'h1);
    endtask

    // refresh passes may add one rows pass when the auto-refresh build is used
    function automatic int row_ok(input int delta, input int n);
`ifdef LED_MATRIX_AUTO_REFRESH_EN
        return int'(delta >= n && delta <= n + 1);
`else
        return int'(delta == n);
`endif
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int f0, r0, t0, wait_n;
        rst_n = 1'b0; fb_we = 1'b0; fb_addr = '0; fb_data = '0; intensity = '0; start = 1'b0;
        tick(3);
        check_eq("rst_stb", 32'(stb_o), 32'h0);
        check_eq("rst_cyc", 32'(cyc_o), 32'h0);
        check_eq("rst_we", 32'(we_o), 32'h0);
        check_eq("rst_sel", 32'(sel_o), 32'h0);
        check_eq("rst_dat", dat_o, 32'h0);
        check_eq("rst_adr", adr_o, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_init", 32'(init_done), 32'h0);
        rst_n = 1'b1;

        // pre-init writes and a stray ack must not cause traffic
        for (int i = 0; i < 100; i++) begin
            if (i < 20 && $urandom_range(1, 0) == 1) begin
                fb_we = 1'b1; fb_addr = 3'($urandom_range(7, 0)); fb_data = 8'($urandom);
            end else begin
                fb_we = 1'b0;
            end
            if (i == 50) stray_req = 1'b1;
            tick(1);
        end
        fb_we = 1'b0;
        check_eq("idle_txns", 32'(txn_count), 32'h0);
        check_eq("idle_busy", 32'(busy), 32'h0);
        check_eq("idle_init", 32'(init_done), 32'h0);

        // init + full refresh
        intensity = 4'h5;
        pulse_start();
        wait_idle("init_idle");
        check_eq("init_runs", 32'(full_runs), 32'd1);
        check_eq("init_done", 32'(init_done), 32'h1);
        check_eq("init_first", 32'(run_words[0]), 32'h0C01);
        check_eq("init_int", 32'(run_words[3]), 32'h0A05);
        check_eq("init_rows", 32'(row_ok(row_runs, 0)), 32'h1);

        // one row write -> one rows pass
        r0 = row_runs;
        write_fb(3'd2, 8'hA5);
        wait_idle("row_idle");
        check_eq("row_pass", 32'(row_ok(row_runs - r0, 1)), 32'h1);
        check_eq("row_a5", 32'(run_words[7]), 32'h03A5);

        // write during a pass -> exactly one further pass
        r0 = row_runs;
        write_fb(3'd0, 8'($urandom));
        wait_busy("mid_busy");
        tick(10);
        write_fb(3'd5, 8'($urandom));
        wait_idle("mid_idle");
        check_eq("mid_passes", 32'(row_ok(row_runs - r0, 2)), 32'h1);

        // starts while busy collapse into one extra full run
        f0 = full_runs;
        lat_lo = 2; lat_hi = 5;
        pulse_start();
        wait_busy("sb_busy");
        tick(5);
        pulse_start();
        tick(20);
        pulse_start();
        wait_idle("sb_idle");
        check_eq("sb_runs", 32'(full_runs - f0), 32'd2);

        // randomized traffic; every transaction is checked by the model
        lat_lo = 2; lat_hi = 6;
        for (int it = 0; it < 6; it++) begin
            intensity = 4'($urandom);
            for (int c = 0; c < 40; c++) begin
                fb_we   = ($urandom_range(3, 0) == 0);
                fb_addr = 3'($urandom_range(7, 0));
                fb_data = 8'($urandom);
                start   = ($urandom_range(15, 0) == 0);
                tick(1);
            end
            fb_we = 1'b0; start = 1'b0;
            wait_idle("rand_idle");
        end
        check_eq("rand_init", 32'(init_done), 32'h1);

`ifdef LED_MATRIX_AUTO_REFRESH_EN
        r0 = row_runs;
        wait_n = 0;
        while (row_runs < r0 + 2 && wait_n < 700) begin tick(1); wait_n++; end
        check_eq("refresh_runs", 32'(row_runs - r0 >= 2), 32'h1);
        check_eq("refresh_period", 32'(row_stamp_last - row_stamp_prev), 32'd200);
`else
        t0 = txn_count;
        tick(450);
        check_eq("no_refresh", 32'(txn_count - t0), 32'h0);
`endif

        // asynchronous reset in the middle of a request
        pulse_start();
        wait_n = 0;
        while (!stb_o && wait_n < 100) begin tick(1); wait_n++; end
        check_eq("abort_stb_seen", 32'(stb_o), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("abort_stb", 32'(stb_o), 32'h0);
        check_eq("abort_cyc", 32'(cyc_o), 32'h0);
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_dat", dat_o, 32'h0);
        check_eq("abort_init", 32'(init_done), 32'h0);
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
